coord_mem_scheduler: RTL



---
 rtl/coord_mem_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 61 ++++++
 rtl/coord_mem_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/coord_mem_pkg.sv
// -----------------------------------------------------------------------------
// coord_mem_pkg
// Shared definitions for the coordinate-memory scheduler and its helpers:
//   - default address/data widths and slot count of the X/Y coordinate memories
//   - phase_t  : accelerator phase (LOAD while collecting points, RUN while
//                the pathfinding engine and debug readback use them)
//   - reader_t : identity of a memory reader, also used as the response tag
// -----------------------------------------------------------------------------
package coord_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } phase_t;

    // Encoding doubles as the requester index in rr_arbiter2 (0 = engine).
    typedef enum logic {
        RD_ENG = 1'b0,
        RD_DBG = 1'b1
    } reader_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter with a registered last-grant pointer.
// A lone requester is always granted; on a tie the requester not granted most
// recently wins. The pointer resets to requester 1 (RD_DBG), so requester 0
// wins the first tie.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high
//   clear_i  in   synchronous pointer reset back to RD_DBG
//   en_i     in   arbitration enabled; grants are 0 when low
//   req_i    in   [1:0] requests, bit 0 = RD_ENG, bit 1 = RD_DBG
//   gnt_o    out  [1:0] one-hot grant, combinational from req_i and pointer
// -----------------------------------------------------------------------------
module rr_arbiter2
    import coord_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    reader_t last_q, last_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[0] && req_i[1]) begin
                gnt_o = (last_q == RD_ENG) ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end

        last_d = last_q;
        if (clear_i) begin
            last_d = RD_DBG;
        end else if (gnt_o[0]) begin
            last_d = RD_ENG;
        end else if (gnt_o[1]) begin
            last_d = RD_DBG;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= RD_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/coord_mem_scheduler.sv
// -----------------------------------------------------------------------------
// coord_mem_scheduler
// Shares the X/Y coordinate memories (common address, one write port, 1-cycle
// synchronous read) between the coordinate collector (writer), the
// pathfinding engine and the debug readback. Owns the LOAD/RUN phase and the
// loaded point count; issues at most one memory access per cycle.
//
// Ports:
//   clk, reset                      clock / asynchronous active-high reset
//   wr_valid, wr_x, wr_y, wr_ready  collector point handshake (LOAD only)
//   load_done                       LOAD -> RUN
//   restart                         RUN -> LOAD, clears point count
//   eng_req/addr/gnt                engine read request, comb. grant
//   dbg_req/addr/gnt                debug read request, comb. grant
//   eng_rvalid/rerr, dbg_rvalid/rerr  tagged response, one cycle after grant
//   rd_x, rd_y                      shared read data, 0 on error
//   mem_addr, mem_wren, mem_*_wdata memory control
//   mem_x_q, mem_y_q                memory read data
//   point_count, running, full      status
// -----------------------------------------------------------------------------
module coord_mem_scheduler
    import coord_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_x,
    input  logic [DATA_W-1:0] wr_y,
    output logic              wr_ready,
    input  logic              load_done,
    input  logic              restart,
    input  logic              eng_req,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic              eng_rerr,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic              dbg_rerr,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_x_wdata,
    output logic [DATA_W-1:0] mem_y_wdata,
    input  logic [DATA_W-1:0] mem_x_q,
    input  logic [DATA_W-1:0] mem_y_q,
    output logic [ADDR_W:0]   point_count,
    output logic              running,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    phase_t          phase_q, phase_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            full_q, full_d;

    // Response stage: one in-flight read, tagged with its owner.
    logic            rvalid_q, rvalid_d;
    logic            rerr_q, rerr_d;
    reader_t         owner_q, owner_d;

    logic            in_run;
    logic            do_restart;
    logic [1:0]      gnt;
    logic [ADDR_W-1:0] rd_addr;

    assign in_run     = (phase_q == RUN);
    assign do_restart = in_run & restart;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .clear_i (do_restart),
        .en_i    (in_run),
        .req_i   ({dbg_req, eng_req}),
        .gnt_o   (gnt)
    );

    assign eng_gnt  = gnt[0];
    assign dbg_gnt  = gnt[1];
    assign wr_ready = ~in_run & wr_valid & ~full_q;
    assign rd_addr  = gnt[1] ? dbg_addr : eng_addr;

    // Memory port mux: collector write in LOAD, granted reader in RUN.
    always_comb begin
        mem_addr    = '0;
        mem_wren    = 1'b0;
        mem_x_wdata = '0;
        mem_y_wdata = '0;
        if (wr_ready) begin
            mem_addr    = count_q[ADDR_W-1:0];
            mem_wren    = 1'b1;
            mem_x_wdata = wr_x;
            mem_y_wdata = wr_y;
        end else if (|gnt) begin
            mem_addr    = rd_addr;
        end
    end

    // Phase FSM and point counter. A write offered with load_done is still
    // counted before the phase flips.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        if (!in_run) begin
            if (wr_ready) begin
                count_d = count_q + ONE_C;
            end
            if (load_done) begin
                phase_d = RUN;
            end
        end else if (restart) begin
            phase_d = LOAD;
            count_d = '0;
        end
        full_d = (count_d == DEPTH_C);
    end

    // The bound check uses the count before any restart clears it, so a read
    // granted in the restart cycle is judged against the load it belongs to.
    always_comb begin
        rvalid_d = |gnt;
        owner_d  = gnt[1] ? RD_DBG : RD_ENG;
        rerr_d   = (|gnt) && ({1'b0, rd_addr} >= count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= LOAD;
            count_q  <= '0;
            full_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            owner_q  <= RD_ENG;
        end else begin
            phase_q  <= phase_d;
            count_q  <= count_d;
            full_q   <= full_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            owner_q  <= owner_d;
        end
    end

    assign eng_rvalid  = rvalid_q & (owner_q == RD_ENG);
    assign dbg_rvalid  = rvalid_q & (owner_q == RD_DBG);
    assign eng_rerr    = eng_rvalid & rerr_q;
    assign dbg_rerr    = dbg_rvalid & rerr_q;
    // Gated by rvalid too, so the shared data bus idles at 0.
    assign rd_x        = (rvalid_q & ~rerr_q) ? mem_x_q : '0;
    assign rd_y        = (rvalid_q & ~rerr_q) ? mem_y_q : '0;
    assign point_count = count_q;
    assign running     = in_run;
    assign full        = full_q;

endmodule
